// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register file write port between a pipeline writeback
// and a FIFO-buffered long-latency result stream, with a pending-register scoreboard.
module regfile_wb_arbiter #(
  parameter int DEPTH = 4,
  parameter int STARVE_MAX = 8,
  parameter logic [1:0] WB_FULL = 2'b00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_valid,
  input  logic [4:0]  a_ws,
  input  logic [31:0] a_wd,
  input  logic [1:0]  a_wb_ctrl,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [4:0]  b_ws,
  input  logic [31:0] b_wd,
  input  logic        iss_valid,
  input  logic [4:0]  iss_rd,
  input  logic [4:0]  q_rs1,
  input  logic [4:0]  q_rs2,
  input  logic [4:0]  q_rd,
  output logic        hazard,
  output logic        stall_pipe,
  output logic        we,
  output logic [4:0]  ws,
  output logic [31:0] wd,
  output logic [1:0]  wb_ctrl,
  output logic        err
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(STARVE_MAX + 1);
  logic [4:0]    ws_mem [DEPTH];
  logic [31:0]   wd_mem [DEPTH];
  logic [AW:0]   wr_q, rd_q;
  logic [SW-1:0] cnt_q, cnt_d;
  logic [31:0]   pend_q, pend_d;
  logic          stall_q, err_q, we_q;
  logic [4:0]    ws_q;
  logic [31:0]   wd_q;
  logic [1:0]    wbc_q;
  logic          empty, full, push, pop, a_win, starve;
  logic [4:0]    head_ws;
  logic [31:0]   head_wd;
  assign empty   = wr_q == rd_q;
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign b_ready = !full && !rst;
  assign push    = b_valid && b_ready;
  assign head_ws = ws_mem[rd_q[AW-1:0]];
  assign head_wd = wd_mem[rd_q[AW-1:0]];
  // a forced bubble hands the port to the FIFO head; otherwise the pipeline has priority
  assign pop     = !empty && (stall_q || !a_valid);
  assign a_win   = a_valid && !stall_q;
  assign starve  = !empty && !pop && cnt_q == SW'(STARVE_MAX - 1);
  assign cnt_d   = (empty || pop || starve) ? '0 : cnt_q + 1'b1;
  always_comb begin
    pend_d = pend_q;
    if (pop) pend_d[head_ws] = 1'b0;
    if (iss_valid) pend_d[iss_rd] = 1'b1;
    pend_d[0] = 1'b0;
  end
  assign hazard     = pend_q[q_rs1] | pend_q[q_rs2] | pend_q[q_rd];
  assign stall_pipe = stall_q;
  assign we         = we_q;
  assign ws         = ws_q;
  assign wd         = wd_q;
  assign wb_ctrl    = wbc_q;
  assign err        = err_q;
  always_ff @(posedge clk) begin
    if (push) begin
      ws_mem[wr_q[AW-1:0]] <= b_ws;
      wd_mem[wr_q[AW-1:0]] <= b_wd;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      pend_q  <= '0;
      stall_q <= 1'b0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      ws_q    <= '0;
      wd_q    <= '0;
      wbc_q   <= '0;
    end else begin
      wr_q    <= wr_q + {{AW{1'b0}}, push};
      rd_q    <= rd_q + {{AW{1'b0}}, pop};
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      stall_q <= starve;
      err_q   <= err_q | (stall_q && a_valid);
      we_q    <= a_win ? a_ws != 5'd0 : pop && head_ws != 5'd0;
      if (a_win) begin
        ws_q  <= a_ws;
        wd_q  <= a_wd;
        wbc_q <= a_wb_ctrl;
      end else if (pop) begin
        ws_q  <= head_ws;
        wd_q  <= head_wd;
        wbc_q <= WB_FULL;
      end
    end
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed scenario bench for the register file write-port arbiter.
module tb_regfile_wb_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic a_valid = 1'b0, b_valid = 1'b0, iss_valid = 1'b0;
  logic [4:0] a_ws = '0, b_ws = '0, iss_rd = '0, q_rs1 = '0, q_rs2 = '0, q_rd = '0;
  logic [31:0] a_wd = '0, b_wd = '0;
  logic [1:0] a_wb_ctrl = '0;
  logic b_ready, hazard, stall_pipe, we, err;
  logic [4:0] ws;
  logic [31:0] wd;
  logic [1:0] wb_ctrl;
  int cmp = 0, bad = 0;
  regfile_wb_arbiter dut (
    .clk(clk), .rst(rst), .a_valid(a_valid), .a_ws(a_ws), .a_wd(a_wd), .a_wb_ctrl(a_wb_ctrl),
    .b_valid(b_valid), .b_ready(b_ready), .b_ws(b_ws), .b_wd(b_wd), .iss_valid(iss_valid),
    .iss_rd(iss_rd), .q_rs1(q_rs1), .q_rs2(q_rs2), .q_rd(q_rd), .hazard(hazard),
    .stall_pipe(stall_pipe), .we(we), .ws(ws), .wd(wd), .wb_ctrl(wb_ctrl), .err(err)
  );
  always #5 clk = ~clk;
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    {a_valid, b_valid, iss_valid} = '0;
    {q_rs1, q_rs2, q_rd} = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    q_rs1 = 5'd7;
    step();
    step();
    cmp++; if (we !== 1'b0) begin bad++; $display("FAIL reset_we got %b exp 0", we); end
    cmp++; if ({ws, wd, wb_ctrl} !== 39'd0) begin bad++; $display("FAIL reset_outs got %h/%h/%b exp 0", ws, wd, wb_ctrl); end
    cmp++; if ({stall_pipe, err, hazard} !== 3'b000) begin bad++; $display("FAIL reset_flags got %b exp 000", {stall_pipe, err, hazard}); end
    cmp++; if (b_ready !== 1'b0) begin bad++; $display("FAIL reset_bready got %b exp 0", b_ready); end
    rst = 1'b0;
    q_rs1 = 5'd0;
    #1;
    cmp++; if (b_ready !== 1'b1) begin bad++; $display("FAIL post_reset_bready got %b exp 1", b_ready); end
  endtask
  task automatic test_a_write;
    do_reset();
    a_valid = 1'b1; a_ws = 5'd5; a_wd = 32'h0000_1234; a_wb_ctrl = 2'b10;
    step();
    a_valid = 1'b0;
    cmp++; if ({we, ws, wd, wb_ctrl} !== {1'b1, 5'd5, 32'h0000_1234, 2'b10}) begin bad++; $display("FAIL a_write got we=%b ws=%0d wd=%h ctrl=%b exp 1/5/00001234/10", we, ws, wd, wb_ctrl); end
    cmp++; if (b_ready !== 1'b1) begin bad++; $display("FAIL a_write_bready got %b exp 1", b_ready); end
    step();
    cmp++; if ({we, ws} !== {1'b0, 5'd5}) begin bad++; $display("FAIL a_idle_hold got we=%b ws=%0d exp 0/5", we, ws); end
  endtask
  task automatic test_scoreboard;
    do_reset();
    iss_valid = 1'b1; iss_rd = 5'd7;
    step();
    iss_valid = 1'b0; q_rs1 = 5'd7;
    #1;
    cmp++; if (hazard !== 1'b1) begin bad++; $display("FAIL sb_hazard_set got %b exp 1", hazard); end
    b_valid = 1'b1; b_ws = 5'd7; b_wd = 32'hDEAD_BEEF;
    step();
    b_valid = 1'b0;
    cmp++; if ({we, hazard} !== 2'b01) begin bad++; $display("FAIL sb_no_bypass got we=%b hz=%b exp 0/1", we, hazard); end
    step();
    cmp++; if ({we, ws, wd, wb_ctrl} !== {1'b1, 5'd7, 32'hDEAD_BEEF, 2'b00}) begin bad++; $display("FAIL sb_b_write got we=%b ws=%0d wd=%h ctrl=%b exp 1/7/deadbeef/00", we, ws, wd, wb_ctrl); end
    cmp++; if (hazard !== 1'b0) begin bad++; $display("FAIL sb_hazard_clear got %b exp 0", hazard); end
    iss_valid = 1'b1; iss_rd = 5'd3;
    step();
    iss_valid = 1'b0; b_valid = 1'b1; b_ws = 5'd3; b_wd = 32'h33;
    step();
    b_valid = 1'b0; iss_valid = 1'b1; iss_rd = 5'd3;
    step();
    iss_valid = 1'b0; q_rs1 = 5'd0; q_rd = 5'd3;
    #1;
    cmp++; if ({we, ws, hazard} !== {1'b1, 5'd3, 1'b1}) begin bad++; $display("FAIL sb_set_wins got we=%b ws=%0d hz=%b exp 1/3/1", we, ws, hazard); end
    q_rd = 5'd0;
  endtask
  task automatic test_starve;
    do_reset();
    a_valid = 1'b1; a_ws = 5'd20; a_wd = 32'hA0; a_wb_ctrl = 2'b01;
    b_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      b_ws = 5'(i); b_wd = 32'h100 + 32'(i);
      step();
    end
    b_valid = 1'b0;
    cmp++; if (b_ready !== 1'b0) begin bad++; $display("FAIL starve_full got b_ready=%b exp 0", b_ready); end
    for (int i = 0; i < 4; i++) begin
      step();
      cmp++; if (stall_pipe !== 1'b0) begin bad++; $display("FAIL starve_early_%0d got %b exp 0", i, stall_pipe); end
    end
    step();
    cmp++; if ({stall_pipe, we, ws} !== {1'b1, 1'b1, 5'd20}) begin bad++; $display("FAIL starve_stall got st=%b we=%b ws=%0d exp 1/1/20", stall_pipe, we, ws); end
    step();
    a_valid = 1'b0;
    cmp++; if ({stall_pipe, we, ws, wd, wb_ctrl} !== {1'b0, 1'b1, 5'd1, 32'h101, 2'b00}) begin bad++; $display("FAIL starve_b_write got st=%b we=%b ws=%0d wd=%h ctrl=%b exp 0/1/1/101/00", stall_pipe, we, ws, wd, wb_ctrl); end
    cmp++; if ({b_ready, err} !== 2'b11) begin bad++; $display("FAIL starve_count3 got b_ready=%b err=%b exp 1/1", b_ready, err); end
    for (int i = 2; i <= 4; i++) begin
      step();
      cmp++; if ({we, ws} !== {1'b1, 5'(i)}) begin bad++; $display("FAIL drain_%0d got we=%b ws=%0d exp 1/%0d", i, we, ws, i); end
    end
    step();
    cmp++; if (we !== 1'b0) begin bad++; $display("FAIL drain_empty got we=%b exp 0", we); end
  endtask
  task automatic test_back_to_back;
    do_reset();
    a_valid = 1'b1; a_ws = 5'd9; a_wd = 32'h11; a_wb_ctrl = 2'b11;
    b_valid = 1'b1; b_ws = 5'd10; b_wd = 32'h22;
    step();
    a_valid = 1'b0; b_valid = 1'b0;
    cmp++; if ({we, ws, wd} !== {1'b1, 5'd9, 32'h11}) begin bad++; $display("FAIL b2b_a_first got we=%b ws=%0d wd=%h exp 1/9/11", we, ws, wd); end
    step();
    cmp++; if ({we, ws, wd, wb_ctrl} !== {1'b1, 5'd10, 32'h22, 2'b00}) begin bad++; $display("FAIL b2b_b_second got we=%b ws=%0d wd=%h ctrl=%b exp 1/10/22/00", we, ws, wd, wb_ctrl); end
  endtask
  task automatic test_x0;
    do_reset();
    iss_valid = 1'b1; iss_rd = 5'd6;
    a_valid = 1'b1; a_ws = 5'd0; a_wd = 32'h55;
    step();
    iss_valid = 1'b0; a_valid = 1'b0;
    cmp++; if (we !== 1'b0) begin bad++; $display("FAIL x0_a got we=%b exp 0", we); end
    b_valid = 1'b1; b_ws = 5'd0; b_wd = 32'h77;
    step();
    b_ws = 5'd8; b_wd = 32'h88;
    step();
    b_valid = 1'b0;
    cmp++; if (we !== 1'b0) begin bad++; $display("FAIL x0_b got we=%b exp 0", we); end
    step();
    q_rd = 5'd6; q_rs1 = 5'd0; q_rs2 = 5'd0;
    #1;
    cmp++; if ({we, ws, wd} !== {1'b1, 5'd8, 32'h88}) begin bad++; $display("FAIL x0_popped got we=%b ws=%0d wd=%h exp 1/8/88", we, ws, wd); end
    cmp++; if (hazard !== 1'b1) begin bad++; $display("FAIL x0_sb_kept got %b exp 1", hazard); end
    q_rd = 5'd0;
    #1;
    cmp++; if (hazard !== 1'b0) begin bad++; $display("FAIL x0_no_hazard got %b exp 0", hazard); end
  endtask
  task automatic test_err_reset;
    bit seen = 1'b0;
    do_reset();
    a_valid = 1'b1; a_ws = 5'd21; a_wd = 32'hCC;
    b_valid = 1'b1;
    for (int i = 11; i <= 13; i++) begin
      b_ws = 5'(i); b_wd = 32'(i);
      step();
    end
    b_valid = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      seen = stall_pipe;
    end
    cmp++; if (seen !== 1'b1) begin bad++; $display("FAIL err_stall_timeout got %b exp 1", seen); end
    step();
    a_valid = 1'b0;
    cmp++; if ({err, we, ws} !== {1'b1, 1'b1, 5'd11}) begin bad++; $display("FAIL err_drop got err=%b we=%b ws=%0d exp 1/1/11", err, we, ws); end
    iss_valid = 1'b1; iss_rd = 5'd15; a_valid = 1'b1; a_ws = 5'd22;
    b_valid = 1'b1; b_ws = 5'd14; b_wd = 32'hEE;
    step();
    iss_valid = 1'b0; b_valid = 1'b0; a_valid = 1'b0;
    rst = 1'b1;
    #1;
    cmp++; if (b_ready !== 1'b0) begin bad++; $display("FAIL rst_bready got %b exp 0", b_ready); end
    step();
    rst = 1'b0; q_rs1 = 5'd15;
    #1;
    cmp++; if ({we, err, stall_pipe, hazard} !== 4'b0000) begin bad++; $display("FAIL mid_reset got we=%b err=%b st=%b hz=%b exp 0000", we, err, stall_pipe, hazard); end
    for (int i = 0; i < 3; i++) begin
      step();
      cmp++; if (we !== 1'b0) begin bad++; $display("FAIL rst_fifo_empty_%0d got we=%b exp 0", i, we); end
    end
    q_rs1 = 5'd0;
  endtask
  initial begin
    test_reset();
    test_a_write();
    test_scoreboard();
    test_starve();
    test_back_to_back();
    test_x0();
    test_err_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port between two requesters:
  - Port A: the in-order pipeline writeback. It is single-cycle and cannot be back-pressured.
  - Port B: the long-latency load/multi-cycle unit. It uses a valid/ready handshake and is buffered in a FIFO.
- Keeps a 32-entry pending scoreboard for B destinations and raises a hazard for dependent issue.
- Forces a pipeline bubble when B results starve.

Parameters:
- DEPTH, 4, B result FIFO entries (power of two, >=2).
- STARVE_MAX, 8, consecutive cycles the FIFO head may wait before a forced bubble.
- WB_FULL, 2'b00, wb_ctrl value driven for B writes (full 32-bit write).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- a_valid  in  1  pipeline writeback request
- a_ws  in  5  pipeline destination register
- a_wd  in  32  pipeline write data
- a_wb_ctrl  in  2  pipeline writeback mode, passed through unchanged
- b_valid  in  1  long-latency result valid
- b_ready  out  1  FIFO can accept a result
- b_ws  in  5  long-latency destination register
- b_wd  in  32  long-latency result data
- iss_valid  in  1  a long-latency op issues this cycle
- iss_rd  in  5  destination of the issuing op
- q_rs1  in  5  source 1 of the instruction in decode
- q_rs2  in  5  source 2 of the instruction in decode
- q_rd  in  5  destination of the instruction in decode
- hazard  out  1  decode instruction depends on a pending register
- stall_pipe  out  1  pipeline must present no A write next cycle
- we  out  1  register file write enable
- ws  out  5  register file write select
- wd  out  32  register file write data
- wb_ctrl  out  2  register file writeback mode
- err  out  1  sticky: A write seen while stall_pipe was high

Behaviour:
- Reset, applied on the clk edge with rst=1:
  - FIFO empty, scoreboard all 0, starve counter 0.
  - we=0, ws=0, wd=0, wb_ctrl=0, stall_pipe=0, err=0.
  - b_ready=0 while rst=1.
  - Reset mid-operation discards FIFO contents and pending bits; no write occurs on that edge.
- b_ready = !full && !rst (combinational). A B transfer occurs when b_valid && b_ready.
- Arbitration is evaluated each cycle; the winner is registered onto we/ws/wd/wb_ctrl (1-cycle latency):
  - stall_pipe=1 and FIFO non-empty: B head wins.
  - Else a_valid=1: A wins. Output = a_ws/a_wd/a_wb_ctrl.
  - Else FIFO non-empty: B head wins. Output = head ws/wd, wb_ctrl=WB_FULL. Pop the FIFO.
  - Else we=0. ws/wd hold their previous values.
- Destination x0 handling:
  - A request with a_ws=0 produces we=0.
  - B entry with ws=0 is popped but produces we=0.
- Empty FIFO + b_valid + no A: the entry is pushed and first appears at the head next cycle. There is no same-cycle bypass.
- Full FIFO with simultaneous pop: b_ready stays 0 that cycle. Push is gated on pre-pop occupancy.
- Starve counter:
  - Increments when FIFO is non-empty and the head is not popped.
  - Resets to 0 on a pop or when the FIFO is empty.
  - When counter == STARVE_MAX-1 and no pop this cycle, stall_pipe=1 next cycle for exactly one cycle; the counter then resets.
- a_valid=1 while stall_pipe=1: the A request is dropped and err is set. err clears only on rst.
- Scoreboard (pending[31:1]):
  - Set on iss_valid with iss_rd!=0.
  - Cleared on the cycle the matching B write is presented (we=1 from B).
  - Simultaneous set and clear of the same register: set wins.
  - pending[0] is always 0.
- hazard (combinational) = pending[q_rs1] | pending[q_rs2] | pending[q_rd] (WAW).
- Registers above use indices !=0; index 0 never hazards.
- FIFO pointers are log2(DEPTH)+1 bits wide; wrap-around is handled by comparing the extra MSB.

Test Plan:
1. Reset, then A writes x5=0x0000_1234 with wb_ctrl=2'b10 -> next cycle we=1, ws=5, wd=0x0000_1234, wb_ctrl=2'b10; b_ready=1.
2. iss_valid with iss_rd=7; q_rs1=7 -> hazard=1. B returns x7=0xDEAD_BEEF with A idle -> two cycles later we=1, ws=7, wb_ctrl=2'b00, and hazard drops to 0 that same cycle.
3. Push 4 B results (x1..x4) while a_valid is held high -> b_ready=0 after the 4th push. After 8 waiting cycles stall_pipe=1 for one cycle, B writes x1, and the FIFO count becomes 3.
4. Same cycle: A (x9=0x11) and B (x10=0x22) arrive with the FIFO empty -> A's write appears first; B's x10 write appears one cycle after A goes idle.
5. A a_ws=0 and B b_ws=0 requests -> we stays 0, the FIFO pops, and no scoreboard change.
6. Drive a_valid=1 during stall_pipe -> err=1 and no A write. Then assert rst mid-stream with FIFO count 3 -> FIFO empty, pending all 0, we=0, err=0.
